rom_responder: RTL and testbench



---
 rtl/rom_pkg.sv | 30 +++
 rtl/bus_phase_tracker.sv | 36 +++
 rtl/rom_responder.sv | 162 ++++++++++++++++
 tb/tb_rom_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared types and opcode constants for the program-memory responder.
// Two-word instruction classification used by the instruction snoop.
package rom_pkg;

  typedef enum logic [3:0] {IDLE, A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

  typedef enum logic [1:0] {IoNone, IoSrc, IoWrr, IoRdr} io_op_t;

  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_FIN_JIN = 4'h3;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;
  localparam logic [3:0] OPR_IO      = 4'hE;
  localparam logic [3:0] OPA_WRR     = 4'h0;
  localparam logic [3:0] OPA_RDR     = 4'hA;

  // FIM and FIN share opcodes with SRC and JIN; OPA[0] distinguishes them.
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    logic result;
    case (opr)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: result = 1'b1;
      OPR_FIM_SRC, OPR_FIN_JIN:           result = ~opa[0];
      default:                            result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/bus_phase_tracker.sv
// Follows the 8-phase instruction cycle of the 4-bit multiplexed bus.
// sync in any phase restarts the cycle at A1; otherwise X3 wraps to A1.
module bus_phase_tracker
  import rom_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   sync,
  output phase_t phase
);

  phase_t phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      IDLE:    phase_d = IDLE;
      X3:      phase_d = A1;
      default: phase_d = phase_t'(phase_q + 4'd1);
    endcase
    if (sync) begin
      phase_d = A1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/rom_responder.sv
// ROM-chip end of the fetch protocol: captures A1/A2/A3, returns the byte in M1/M2.
// Define ROM_IO_PORT_EN to add the SRC/WRR/RDR I/O port.
module rom_responder
  import rom_pkg::*;
#(
  parameter logic [3:0]    CHIP_ID     = 4'h0,
  parameter string         ROM_FILE    = "rom.hex",
  parameter bit            ROM_FILE_EN = 1'b1,
  parameter logic [2047:0] ROM_IMAGE   = '0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sync,
  input  logic       cmd_rom,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  phase_t     phase;
  logic [7:0] rom_byte;

  logic [7:0] addr_q, addr_d;
  logic       sel_q, sel_d;
  logic [3:0] opr_q, opr_d;
  logic       skip_next_q, skip_next_d;
  logic       data_oe_q, data_oe_d;
  logic [3:0] data_out_q, data_out_d;

  bus_phase_tracker u_phase (
    .clock (clock),
    .reset (reset),
    .sync  (sync),
    .phase (phase)
  );

  logic unused_file_en;
  assign unused_file_en = ROM_FILE_EN;
  assign rom_byte       = ROM_IMAGE[{addr_q, 3'b000} +: 8];

`ifdef ROM_IO_PORT_EN
  io_op_t     io_op_q, io_op_d;
  logic       io_sel_q, io_sel_d;
  logic [3:0] io_out_q, io_out_d;
`else
  logic       unused_io;
  assign unused_io = ^{io_in, cmd_rom};
`endif

  // Outputs are registered, so each drive is set up one phase early and
  // suppressed when sync is about to restart the cycle.
  always_comb begin
    addr_d      = addr_q;
    sel_d       = sel_q;
    opr_d       = opr_q;
    skip_next_d = skip_next_q;
    data_oe_d   = 1'b0;
    data_out_d  = 4'h0;
`ifdef ROM_IO_PORT_EN
    io_op_d  = io_op_q;
    io_sel_d = io_sel_q;
    io_out_d = io_out_q;
`endif
    case (phase)
      A1: addr_d[3:0] = data_in;
      A2: addr_d[7:4] = data_in;
      A3: begin
        sel_d = (data_in == CHIP_ID);
        if (sel_d && !sync) begin
          data_oe_d  = 1'b1;
          data_out_d = rom_byte[7:4];
        end
      end
      M1: begin
        opr_d = data_in;
        if (sel_q && !sync) begin
          data_oe_d  = 1'b1;
          data_out_d = rom_byte[3:0];
        end
      end
      M2: begin
        // The operand byte of a two-word instruction is never decoded.
        if (skip_next_q) begin
          skip_next_d = 1'b0;
        end else begin
          skip_next_d = is_two_word(opr_q, data_in);
        end
`ifdef ROM_IO_PORT_EN
        io_op_d = IoNone;
        if (!skip_next_q) begin
          if (opr_q == OPR_FIM_SRC && data_in[0]) begin
            io_op_d = IoSrc;
          end else if (opr_q == OPR_IO && data_in == OPA_WRR) begin
            io_op_d = IoWrr;
          end else if (opr_q == OPR_IO && data_in == OPA_RDR) begin
            io_op_d = IoRdr;
          end
        end
`endif
      end
`ifdef ROM_IO_PORT_EN
      X1: begin
        if (io_op_q == IoRdr && io_sel_q && !sync) begin
          data_oe_d  = 1'b1;
          data_out_d = io_in;
        end
      end
      X2: begin
        if (io_op_q == IoSrc && cmd_rom) begin
          io_sel_d = (data_in == CHIP_ID);
        end
        if (io_op_q == IoWrr && io_sel_q) begin
          io_out_d = data_in;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= 8'h00;
      sel_q       <= 1'b0;
      opr_q       <= 4'h0;
      skip_next_q <= 1'b0;
      data_oe_q   <= 1'b0;
      data_out_q  <= 4'h0;
    end else begin
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      opr_q       <= opr_d;
      skip_next_q <= skip_next_d;
      data_oe_q   <= data_oe_d;
      data_out_q  <= data_out_d;
    end
  end

`ifdef ROM_IO_PORT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      io_op_q  <= IoNone;
      io_sel_q <= 1'b0;
      io_out_q <= 4'h0;
    end else begin
      io_op_q  <= io_op_d;
      io_sel_q <= io_sel_d;
      io_out_q <= io_out_d;
    end
  end

  assign io_out = io_out_q;
`else
  assign io_out = 4'h0;
`endif

  assign data_oe  = data_oe_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_rom_responder.sv
// Directed, table-driven bench for rom_responder: one record per bus phase.
// I/O port expectations follow ROM_IO_PORT_EN.
module tb_rom_responder;

  localparam logic [3:0] CHIP = 4'h2;
`ifdef ROM_IO_PORT_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  function automatic logic [2047:0] build_image();
    logic [2047:0] img;
    img = '0;
    img['h13*8 +: 8] = 8'hD5;
    img['h40*8 +: 8] = 8'h9B;
    img['h30*8 +: 8] = 8'h21;  // SRC
    img['h31*8 +: 8] = 8'hE0;  // WRR
    img['h32*8 +: 8] = 8'hEA;  // RDR
    img['h20*8 +: 8] = 8'h40;  // JUN
    img['h21*8 +: 8] = 8'hE0;
    img['h22*8 +: 8] = 8'hE0;
    img['h23*8 +: 8] = 8'h40;
    return img;
  endfunction

  localparam logic [2047:0] IMAGE = build_image();

  logic       clock = 1'b0;
  logic       reset, sync, cmd_rom, data_oe;
  logic [3:0] data_in, data_out, io_in, io_out;

  always #5 clock = ~clock;

  rom_responder #(
    .CHIP_ID     (CHIP),
    .ROM_FILE    (""),
    .ROM_FILE_EN (1'b0),
    .ROM_IMAGE   (IMAGE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .sync     (sync),
    .cmd_rom  (cmd_rom),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .io_in    (io_in),
    .io_out   (io_out)
  );

  typedef struct {
    bit         rst;
    bit         sync;
    bit         cmd;
    logic [3:0] din;
    logic [3:0] ioin;
    bit         chk;
    bit         exp_oe;
    bit         chk_out;
    logic [3:0] exp_out;
    logic [3:0] exp_io;
  } vec_t;

  vec_t       vecs[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] io_exp = 4'h0;

  task automatic push(input bit rst, input bit sy, input bit cmd, input logic [3:0] din,
                      input logic [3:0] ioin, input bit chk, input bit oe, input bit chk_out,
                      input logic [3:0] out, input logic [3:0] io);
    vec_t v;
    v.rst = rst; v.sync = sy; v.cmd = cmd; v.din = din; v.ioin = ioin;
    v.chk = chk; v.exp_oe = oe; v.chk_out = chk_out; v.exp_out = out; v.exp_io = io;
    vecs.push_back(v);
  endtask

  // One instruction cycle A1..X3; X2 drive expectation is io_in when x2oe.
  task automatic add_instr(input logic [7:0] addr, input logic [3:0] a3,
                           input logic [7:0] bus_byte, input bit sel, input bit cmd,
                           input logic [3:0] x2din, input logic [3:0] ioin, input bit x2oe,
                           input logic [3:0] io_post, input bit next_sync);
    push(0, 0, 0, addr[3:0], ioin, 1, 0, 0, 4'h0, io_exp);
    push(0, 0, 0, addr[7:4], ioin, 1, 0, 0, 4'h0, io_exp);
    push(0, 0, 0, a3, ioin, 1, 0, 0, 4'h0, io_exp);
    push(0, 0, 0, bus_byte[7:4], ioin, 1, sel, sel, bus_byte[7:4], io_exp);
    push(0, 0, 0, bus_byte[3:0], ioin, 1, sel, sel, bus_byte[3:0], io_exp);
    push(0, 0, 0, 4'h0, ioin, 1, 0, 0, 4'h0, io_exp);
    push(0, 0, cmd, x2din, ioin, 1, x2oe, x2oe, ioin, io_exp);
    push(0, next_sync, 0, 4'h0, ioin, 1, 0, 0, 4'h0, io_post);
    io_exp = io_post;
  endtask

  initial begin
    // Reset, then idle with reset values visible.
    push(1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    push(1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    push(0, 0, 0, 4'h3, 4'h0, 1, 0, 1, 4'h0, 4'h0);
    push(0, 1, 0, 4'h0, 4'h0, 1, 0, 1, 4'h0, 4'h0);

    // Selected fetch, deselected fetch ending without sync, fetch after wrap.
    add_instr(8'h13, CHIP, 8'hD5, 1, 0, 4'h0, 4'h0, 0, io_exp, 1);
    add_instr(8'h13, CHIP + 4'h1, 8'hD5, 0, 0, 4'h0, 4'h0, 0, io_exp, 0);
    add_instr(8'h40, CHIP, 8'h9B, 1, 0, 4'h0, 4'h0, 0, io_exp, 1);

    // Resync asserted in M2 of a fetch.
    push(0, 0, 0, 4'h3, 4'h0, 1, 0, 0, 4'h0, io_exp);
    push(0, 0, 0, 4'h1, 4'h0, 1, 0, 0, 4'h0, io_exp);
    push(0, 0, 0, CHIP, 4'h0, 1, 0, 0, 4'h0, io_exp);
    push(0, 0, 0, 4'hD, 4'h0, 1, 1, 1, 4'hD, io_exp);
    push(0, 1, 0, 4'h5, 4'h0, 1, 1, 1, 4'h5, io_exp);
    add_instr(8'h40, CHIP, 8'h9B, 1, 0, 4'h0, 4'h0, 0, io_exp, 1);

    // I/O port: SRC, WRR, RDR.
    add_instr(8'h30, CHIP, 8'h21, 1, 1, CHIP, 4'h0, 0, io_exp, 1);
    add_instr(8'h31, CHIP, 8'hE0, 1, 0, 4'hA, 4'h0, 0, IO_EN ? 4'hA : 4'h0, 1);
    add_instr(8'h32, CHIP, 8'hEA, 1, 0, IO_EN ? 4'h6 : 4'h0, 4'h6, IO_EN, io_exp, 1);

    // Two-word skip: operand E0 ignored; skipped 0x40 must not chain.
    add_instr(8'h20, CHIP, 8'h40, 1, 0, 4'h0, 4'h0, 0, io_exp, 1);
    add_instr(8'h21, CHIP, 8'hE0, 1, 0, 4'h5, 4'h0, 0, io_exp, 1);
    add_instr(8'h20, CHIP, 8'h40, 1, 0, 4'h0, 4'h0, 0, io_exp, 1);
    add_instr(8'h23, CHIP, 8'h40, 1, 0, 4'h0, 4'h0, 0, io_exp, 1);
    add_instr(8'h22, CHIP, 8'hE0, 1, 0, 4'h7, 4'h0, 0, IO_EN ? 4'h7 : 4'h0, 1);

    // Reset in M1, then idle without sync, then a clean fetch.
    push(0, 0, 0, 4'h3, 4'h0, 1, 0, 0, 4'h0, io_exp);
    push(0, 0, 0, 4'h1, 4'h0, 1, 0, 0, 4'h0, io_exp);
    push(0, 0, 0, CHIP, 4'h0, 1, 0, 0, 4'h0, io_exp);
    push(1, 0, 0, 4'hD, 4'h0, 1, 1, 1, 4'hD, io_exp);
    io_exp = 4'h0;
    for (int i = 0; i < 9; i++) begin
      push(0, 0, 0, (i % 2 == 0) ? CHIP : 4'h3, 4'h0, 1, 0, 1, 4'h0, 4'h0);
    end
    push(0, 1, 0, 4'h0, 4'h0, 1, 0, 1, 4'h0, 4'h0);
    add_instr(8'h13, CHIP, 8'hD5, 1, 0, 4'h0, 4'h0, 0, io_exp, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].chk) begin
        checks++;
        if (data_oe !== vecs[i].exp_oe) begin
          errors++;
          $display("FAIL vec %0d data_oe: got %b want %b", i, data_oe, vecs[i].exp_oe);
        end
        checks++;
        if (io_out !== vecs[i].exp_io) begin
          errors++;
          $display("FAIL vec %0d io_out: got %h want %h", i, io_out, vecs[i].exp_io);
        end
        if (vecs[i].chk_out) begin
          checks++;
          if (data_out !== vecs[i].exp_out) begin
            errors++;
            $display("FAIL vec %0d data_out: got %h want %h", i, data_out, vecs[i].exp_out);
          end
        end
      end
      reset   = vecs[i].rst;
      sync    = vecs[i].sync;
      cmd_rom = vecs[i].cmd;
      data_in = vecs[i].din;
      io_in   = vecs[i].ioin;
      @(posedge clock);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
